// File: rtl/cva6_lsu_mem_pkg.sv
// Shared types and helpers for the CVA6 LSU memory-response model.
package cva6_lsu_mem_pkg;

  localparam int unsigned MEM_ADDR_W    = 32;
  localparam int unsigned TIMER_W       = 8;
  localparam int unsigned LAT_LOAD_DEF  = 3;
  localparam int unsigned LAT_STORE_DEF = 2;

  // One queued memory request; timer counts down to its response cycle.
  typedef struct packed {
    logic                  is_load;
    logic [MEM_ADDR_W-1:0] addr;
    logic [TIMER_W-1:0]    timer;
  } mem_req_t;

  // Initial timer value for a request of the given type.
  function automatic logic [TIMER_W-1:0] lat_of(input logic        is_load,
                                                input int unsigned lat_ld = LAT_LOAD_DEF,
                                                input int unsigned lat_st = LAT_STORE_DEF);
    return is_load ? TIMER_W'(lat_ld) : TIMER_W'(lat_st);
  endfunction

endpackage

// File: rtl/cva6_lsu_mem_fifo.sv
// DEPTH-entry circular buffer of mem_req_t; every entry is exposed and
// rewritten each cycle from upd_i so the parent can age timers in place.
module cva6_lsu_mem_fifo
  import cva6_lsu_mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  mem_req_t               push_data_i,
  input  logic                   pop_i,
  input  mem_req_t [DEPTH-1:0]   upd_i,
  output mem_req_t [DEPTH-1:0]   entries_o,
  output logic     [PTR_W-1:0]   rd_ptr_o,
  output logic     [CNT_W-1:0]   count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  mem_req_t [DEPTH-1:0] mem_q, mem_d;
  logic     [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic     [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic     [CNT_W-1:0] count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;

  // Never overwrite a live entry or pop an empty queue.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = upd_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cva6_lsu_mem_resp_gen.sv
// In-order memory responder for the CVA6 LSU: queues requests and pulses
// load/store responses LAT_LOAD / LAT_STORE cycles after acceptance.
// Optional macro CVA6_LSU_MEM_STALL_EN adds resp_stall_i to hold the head.
module cva6_lsu_mem_resp_gen
  import cva6_lsu_mem_pkg::*;
#(
  parameter  int unsigned LAT_LOAD  = LAT_LOAD_DEF,
  parameter  int unsigned LAT_STORE = LAT_STORE_DEF,
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned ADDR_W    = 32,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_is_load_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              load_mem_resp_o,
  output logic              store_mem_resp_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic [CNT_W-1:0]  outstanding_o
`ifdef CVA6_LSU_MEM_STALL_EN
  ,
  input  logic              resp_stall_i
`endif
);

  mem_req_t [DEPTH-1:0] entries;
  mem_req_t [DEPTH-1:0] upd;
  mem_req_t             push_data;
  mem_req_t             head;
  logic     [PTR_W-1:0] rd_ptr;
  logic     [CNT_W-1:0] count;
  logic                 full, empty;
  logic                 push, head_fire, stall;

`ifdef CVA6_LSU_MEM_STALL_EN
  assign stall = resp_stall_i;
`else
  assign stall = 1'b0;
`endif

  // Ready comes from registered occupancy only; a pop never frees a slot early.
  assign req_ready_o   = !full;
  assign outstanding_o = count;
  assign push          = req_valid_i && req_ready_o;

  assign push_data = '{is_load: req_is_load_i,
                       addr:    MEM_ADDR_W'(req_addr_i),
                       timer:   lat_of(req_is_load_i, LAT_LOAD, LAT_STORE)};

  // Saturating timer decrement for every entry; the freshly pushed slot is
  // replaced inside the FIFO, so it first ages on the following edge.
  always_comb begin
    upd = entries;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entries[i].timer != '0) begin
        upd[i].timer = entries[i].timer - TIMER_W'(1);
      end
    end
  end

  // Only the head may respond; younger expired entries wait their turn.
  assign head      = entries[rd_ptr];
  assign head_fire = !empty && (head.timer == '0) && !stall;

  assign load_mem_resp_o  = head_fire && head.is_load;
  assign store_mem_resp_o = head_fire && !head.is_load;
  assign resp_addr_o      = head_fire ? ADDR_W'(head.addr) : '0;

  cva6_lsu_mem_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (head_fire),
    .upd_i      (upd),
    .entries_o  (entries),
    .rd_ptr_o   (rd_ptr),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

endmodule
